// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle processor control FSM: fetch/decode/execute sequencing with
// memory latency waits, UART send/receive with optional timeout, and FPU handshake.
module mc_ctrl_fsm #(
  parameter int MEM_LAT = 2,
  parameter int UART_TO = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] op,
  input  logic       uart_done,
  input  logic       fpu_done,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcbufwrite,
  output logic       iord,
  output logic       branch,
  output logic       rors,
  output logic       uart_go,
  output logic       fpu_go,
  output logic       illegal,
  output logic       uart_err,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] regsrc,
  output logic [2:0] aluop
);

  typedef enum logic [4:0] {
    FETCH, FWAIT, FVALID, DECODE, MEMADR, MREAD, MWAIT, MVALID, MWB, MWRITE,
    EXEC, AWB, BRANCH, IEXEC, IWB, LUIEX, AUIPCEX, JALEX, JALREX,
    SEND_GO, SEND_WAIT, RECV_GO, RECV_WAIT, RECV_WB, FPU_GO, FPU_WAIT, FPU_WB
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SEND  = 7'b0000010;
  localparam logic [6:0] OP_RECV  = 7'b0000001;
  localparam logic [6:0] OP_FPU   = 7'b1010011;

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int TO_W  = 20;

  // The wait state is occupied MEM_LAT-1 cycles, so the counter starts at
  // MEM_LAT-2 and the exit happens in the cycle it reads zero.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((UART_TO > 0) ? UART_TO - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              op_legal;
  logic              to_hit;

  always_comb begin
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BR, OP_LUI, OP_AUIPC,
      OP_JAL, OP_JALR, OP_SEND, OP_RECV, OP_FPU: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  // A simultaneous uart_done wins over the timeout.
  assign to_hit = (UART_TO > 0) && !uart_done && (to_q == TO_LAST);

  // NOTE: non-blocking assignments for all state; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FETCH;
      lat_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    to_d    = to_q;
    case (state_q)
      FETCH: begin
        if (MEM_LAT > 1) begin
          state_d = FWAIT;
          lat_d   = LAT_LOAD;
        end else begin
          state_d = FVALID;
        end
      end
      FWAIT: begin
        if (lat_q == '0) state_d = FVALID;
        else             lat_d   = lat_q - CNT_W'(1);
      end
      FVALID: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXEC;
          OP_ITYPE:          state_d = IEXEC;
          OP_BR:             state_d = BRANCH;
          OP_LUI:            state_d = LUIEX;
          OP_AUIPC:          state_d = AUIPCEX;
          OP_JAL:            state_d = JALEX;
          OP_JALR:           state_d = JALREX;
          OP_SEND:           state_d = SEND_GO;
          OP_RECV:           state_d = RECV_GO;
          OP_FPU:            state_d = FPU_GO;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LOAD)       state_d = MREAD;
        else if (op == OP_STORE) state_d = MWRITE;
        else                     state_d = FETCH;
      end
      MREAD: begin
        if (MEM_LAT > 1) begin
          state_d = MWAIT;
          lat_d   = LAT_LOAD;
        end else begin
          state_d = MVALID;
        end
      end
      MWAIT: begin
        if (lat_q == '0) state_d = MVALID;
        else             lat_d   = lat_q - CNT_W'(1);
      end
      MVALID:  state_d = MWB;
      MWB:     state_d = FETCH;
      MWRITE:  state_d = FETCH;
      EXEC:    state_d = AWB;
      AWB:     state_d = FETCH;
      IEXEC:   state_d = IWB;
      IWB:     state_d = FETCH;
      BRANCH, LUIEX, AUIPCEX, JALEX, JALREX: state_d = FETCH;
      SEND_GO: begin
        state_d = SEND_WAIT;
        to_d    = '0;
      end
      SEND_WAIT: begin
        to_d = to_q + TO_W'(1);
        if (uart_done || to_hit) state_d = FETCH;
      end
      RECV_GO: begin
        state_d = RECV_WAIT;
        to_d    = '0;
      end
      RECV_WAIT: begin
        to_d = to_q + TO_W'(1);
        if (uart_done)   state_d = RECV_WB;
        else if (to_hit) state_d = FETCH;
      end
      RECV_WB:  state_d = FETCH;
      FPU_GO:   state_d = FPU_WAIT;
      FPU_WAIT: if (fpu_done) state_d = FPU_WB;
      FPU_WB:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    pcbufwrite = 1'b0;
    iord       = 1'b0;
    branch     = 1'b0;
    rors       = 1'b0;
    uart_go    = 1'b0;
    fpu_go     = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    regsrc     = 3'b000;
    aluop      = 3'b000;
    illegal    = (state_q == DECODE) && !op_legal;
    uart_err   = ((state_q == SEND_WAIT) || (state_q == RECV_WAIT)) && to_hit;
    case (state_q)
      FETCH: begin
        pcwrite    = 1'b1;
        pcbufwrite = 1'b1;
        alusrcb    = 2'b01;
      end
      FVALID: irwrite = 1'b1;
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b10;
      end
      MREAD, MWAIT, MVALID: iord = 1'b1;
      MWB: begin
        regwrite = 1'b1;
        regsrc   = 3'b001;
      end
      MWRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      EXEC: begin
        alusrca = 2'b10;
        aluop   = 3'b100;
      end
      AWB, IWB, AUIPCEX: regwrite = 1'b1;
      BRANCH: begin
        alusrca = 2'b10;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        aluop   = 3'b111;
      end
      IEXEC: begin
        alusrca = 2'b10;
        alusrcb = 2'b10;
        aluop   = 3'b101;
      end
      LUIEX: begin
        regwrite = 1'b1;
        regsrc   = 3'b010;
      end
      JALEX: begin
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        regsrc   = 3'b011;
        pcsrc    = 2'b01;
      end
      JALREX: begin
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        alusrca  = 2'b10;
        alusrcb  = 2'b10;
        regsrc   = 3'b011;
        pcsrc    = 2'b10;
      end
      SEND_GO: begin
        rors    = 1'b1;
        uart_go = 1'b1;
      end
      SEND_WAIT: rors = 1'b1;
      RECV_GO:   uart_go = 1'b1;
      RECV_WB: begin
        regwrite = 1'b1;
        regsrc   = 3'b100;
      end
      FPU_GO: begin
        fpu_go  = 1'b1;
        alusrca = 2'b10;
      end
      FPU_WB: begin
        regwrite = 1'b1;
        regsrc   = 3'b101;
      end
      FWAIT, RECV_WAIT, FPU_WAIT: ;
      default: begin
        illegal  = 1'b0;
        uart_err = 1'b0;
      end
    endcase
  end

endmodule
